// File: rtl/calc_bin2bcd_if.sv
// Handshake bundle between the calculator core and the binary-to-BCD display stage.
// The master drives start/bin_in. The slave (converter) returns status and the result.
interface calc_bin2bcd_if #(
    parameter int BITS   = 32,
    parameter int DIGITS = 10
);
    logic                  start;
    logic [BITS-1:0]       bin_in;
    logic                  busy;
    logic                  done;
    logic [DIGITS*4-1:0]   bcd_out;
    logic                  negative;
    logic                  overflow;

    modport master (output start, bin_in, input busy, done, bcd_out, negative, overflow);
    modport slave  (input start, bin_in, output busy, done, bcd_out, negative, overflow);
endinterface

// File: rtl/calc_bin2bcd.sv
// Sequential double-dabble converter. It shifts in one magnitude bit per clock.
// Results are held until the next completed conversion.
module calc_bin2bcd #(
    parameter int BITS   = 32,
    parameter int DIGITS = 10,
    parameter bit SIGNED = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    calc_bin2bcd_if.slave  bus
);
    localparam int CW = $clog2(BITS + 1);
    localparam int DW = DIGITS * 4;

    typedef enum logic {IDLE, CONV} state_t;
    state_t state_q, state_d;

    logic [BITS-1:0]         mag_q;
    logic [DIGITS-1:0][3:0]  dig_q;
    logic [DIGITS-1:0][3:0]  dig_adj;
    logic [DW-1:0]           adj_flat;
    logic [DW-1:0]           dig_shift;
    logic [CW-1:0]           cnt_q;
    logic                    sign_q, ovf_q;
    logic [DW-1:0]           bcd_q;
    logic                    neg_q, ovf_out_q, done_q;
    logic                    accept, last, carry, in_neg;
    logic [BITS-1:0]         in_mag;

    // Most negative input negates to itself, which reads correctly as an unsigned magnitude.
    assign in_neg = SIGNED && bus.bin_in[BITS-1];
    assign in_mag = in_neg ? (~bus.bin_in + BITS'(1)) : bus.bin_in;

    for (genvar d = 0; d < DIGITS; d++) begin : g_adj
        assign dig_adj[d] = (dig_q[d] >= 4'd5) ? dig_q[d] + 4'd3 : dig_q[d];
    end

    assign adj_flat  = dig_adj;
    assign carry     = adj_flat[DW-1];
    assign dig_shift = {adj_flat[DW-2:0], mag_q[BITS-1]};
    assign accept    = (state_q == IDLE) && bus.start;
    assign last      = (cnt_q == CW'(BITS - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = CONV;
            CONV:    if (last)      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mag_q     <= '0;
            dig_q     <= '0;
            cnt_q     <= '0;
            sign_q    <= 1'b0;
            ovf_q     <= 1'b0;
            bcd_q     <= '0;
            neg_q     <= 1'b0;
            ovf_out_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                mag_q  <= in_mag;
                sign_q <= in_neg;
                dig_q  <= '0;
                ovf_q  <= 1'b0;
                cnt_q  <= '0;
            end else if (state_q == CONV) begin
                mag_q <= mag_q << 1;
                dig_q <= dig_shift;
                ovf_q <= ovf_q | carry;
                cnt_q <= cnt_q + CW'(1);
                if (last) begin
                    bcd_q     <= dig_shift;
                    neg_q     <= sign_q;
                    ovf_out_q <= ovf_q | carry;
                    done_q    <= 1'b1;
                end
            end
        end
    end

    assign bus.busy     = (state_q == CONV);
    assign bus.done     = done_q;
    assign bus.bcd_out  = bcd_q;
    assign bus.negative = neg_q;
    assign bus.overflow = ovf_out_q;
endmodule

// File: tb/tb_calc_bin2bcd.sv
// Scoreboard bench for calc_bin2bcd. It covers three configurations: signed 32-bit,
// unsigned 8-bit with 2 digits, and unsigned 32-bit. Expected results come from decimal arithmetic.
module tb_calc_bin2bcd;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    calc_bin2bcd_if #(.BITS(32), .DIGITS(10)) ia ();
    calc_bin2bcd_if #(.BITS(8),  .DIGITS(2))  ib ();
    calc_bin2bcd_if #(.BITS(32), .DIGITS(10)) ic ();

    calc_bin2bcd #(.BITS(32), .DIGITS(10), .SIGNED(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(ia.slave));
    calc_bin2bcd #(.BITS(8),  .DIGITS(2),  .SIGNED(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(ib.slave));
    calc_bin2bcd #(.BITS(32), .DIGITS(10), .SIGNED(1'b0)) dut_c (.clk(clk), .rst(rst), .bus(ic.slave));

    typedef struct {
        logic [39:0] bcd;
        logic        neg;
        logic        ovf;
        int          acc;
    } exp_t;

    exp_t qa[$], qb[$], qc[$];
    exp_t ea, eb, ec;
    int cyc = 0;
    int n_chk = 0;
    int n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(logic [31:0] v, int bits, int digits, bit sgn);
        exp_t e;
        longint unsigned full, m, lim;
        full  = 64'd1 << bits;
        m     = 64'(v) & (full - 1);
        e.neg = sgn && v[bits-1];
        if (e.neg) m = full - m;
        lim = 1;
        for (int i = 0; i < digits; i++) lim = lim * 10;
        e.ovf = (m >= lim);
        e.bcd = '0;
        for (int i = 0; i < digits; i++) begin
            e.bcd[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
        e.acc = 0;
        return e;
    endfunction

    task automatic check(string name, logic [39:0] act, logic [39:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (!rst) begin
            if (qa.size() == 0) begin
                check("a idle done", 40'(ia.done), 40'(0));
                check("a idle busy", 40'(ia.busy), 40'(0));
            end else if (ia.done) begin
                ea = qa.pop_front();
                check("a bcd", 40'(ia.bcd_out), ea.bcd);
                check("a negative", 40'(ia.negative), 40'(ea.neg));
                check("a overflow", 40'(ia.overflow), 40'(ea.ovf));
                check("a latency", 40'(cyc), 40'(ea.acc + 32));
                check("a busy at done", 40'(ia.busy), 40'(0));
            end else check("a busy", 40'(ia.busy), 40'(1));
        end
    end

    always @(posedge clk) begin
        #1;
        if (!rst) begin
            if (qb.size() == 0) begin
                check("b idle done", 40'(ib.done), 40'(0));
                check("b idle busy", 40'(ib.busy), 40'(0));
            end else if (ib.done) begin
                eb = qb.pop_front();
                check("b bcd", 40'(ib.bcd_out), eb.bcd);
                check("b negative", 40'(ib.negative), 40'(0));
                check("b overflow", 40'(ib.overflow), 40'(eb.ovf));
                check("b latency", 40'(cyc), 40'(eb.acc + 8));
            end else check("b busy", 40'(ib.busy), 40'(1));
        end
    end

    always @(posedge clk) begin
        #1;
        if (!rst) begin
            if (qc.size() == 0) begin
                check("c idle done", 40'(ic.done), 40'(0));
                check("c idle busy", 40'(ic.busy), 40'(0));
            end else if (ic.done) begin
                ec = qc.pop_front();
                check("c bcd", 40'(ic.bcd_out), ec.bcd);
                check("c negative", 40'(ic.negative), 40'(0));
                check("c overflow", 40'(ic.overflow), 40'(ec.ovf));
                check("c latency", 40'(cyc), 40'(ec.acc + 32));
            end else check("c busy", 40'(ic.busy), 40'(1));
        end
    end

    function automatic logic busy_of(int which);
        case (which)
            0:       return ia.busy;
            1:       return ib.busy;
            default: return ic.busy;
        endcase
    endfunction

    // Called at a negedge. Waits for the instance to go idle, then presents start for one cycle.
    task automatic go(int which, logic [31:0] v);
        int t = 0;
        exp_t e;
        while (busy_of(which) && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            n_chk++;
            n_bad++;
            $display("FAIL idle wait: instance %0d still busy after %0d cycles", which, t);
        end
        case (which)
            0: begin
                ia.start = 1'b1; ia.bin_in = v;
                e = model(v, 32, 10, 1'b1); e.acc = cyc + 1; qa.push_back(e);
            end
            1: begin
                ib.start = 1'b1; ib.bin_in = v[7:0];
                e = model(v, 8, 2, 1'b0); e.acc = cyc + 1; qb.push_back(e);
            end
            default: begin
                ic.start = 1'b1; ic.bin_in = v;
                e = model(v, 32, 10, 1'b0); e.acc = cyc + 1; qc.push_back(e);
            end
        endcase
        @(negedge clk);
        ia.start = 1'b0;
        ib.start = 1'b0;
        ic.start = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((qa.size() != 0 || qb.size() != 0 || qc.size() != 0) && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) begin
            n_chk++;
            n_bad++;
            $display("FAIL drain: results outstanding a=%0d b=%0d c=%0d", qa.size(), qb.size(), qc.size());
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        ia.start = 1'b0; ia.bin_in = '0;
        ib.start = 1'b0; ib.bin_in = '0;
        ic.start = 1'b0; ic.bin_in = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset bcd", 40'(ia.bcd_out), 40'(0));
        check("reset negative", 40'(ia.negative), 40'(0));
        check("reset overflow", 40'(ia.overflow), 40'(0));
        check("reset busy", 40'(ia.busy), 40'(0));
        check("reset done", 40'(ia.done), 40'(0));

        go(0, 32'd0);
        go(0, 32'd12345);
        go(0, 32'hFFFF_FFFF);
        go(0, 32'h8000_0000);
        go(0, 32'hFFFF_CFC7);
        go(2, 32'hFFFF_FFFF);
        go(2, 32'd0);
        go(1, 32'd255);
        go(1, 32'd99);
        go(1, 32'd100);
        go(1, 32'd0);
        drain();

        for (int i = 0; i < 30; i++) go(0, (i % 4 == 0) ? 32'($urandom_range(0, 999)) : 32'($urandom));
        for (int i = 0; i < 20; i++) go(1, 32'($urandom_range(0, 255)));
        for (int i = 0; i < 15; i++) go(2, 32'($urandom));
        drain();

        // A second start mid-conversion with a new bin_in must leave no trace.
        go(0, 32'd987654);
        repeat (3) @(negedge clk);
        ia.start = 1'b1;
        ia.bin_in = 32'd42;
        @(negedge clk);
        ia.start = 1'b0;
        drain();

        // Reset lands on edge 10 of a conversion; the result is abandoned.
        go(0, 32'd55555);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        qa.delete();
        @(negedge clk);
        rst = 1'b0;
        check("abort bcd", 40'(ia.bcd_out), 40'(0));
        check("abort negative", 40'(ia.negative), 40'(0));
        check("abort overflow", 40'(ia.overflow), 40'(0));
        check("abort busy", 40'(ia.busy), 40'(0));
        check("abort done", 40'(ia.done), 40'(0));
        @(negedge clk);
        go(0, 32'd777);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
        $finish;
    end
endmodule
